// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: WB stage vs buffered multi-cycle results.
// Optional pending-write query ports enabled by defining WB_PEND_QUERY_EN.
module wb_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pipe_we,
  input  logic [4:0]                    pipe_rd,
  input  logic [XLEN-1:0]               pipe_data,
  input  logic                          mc_valid,
  input  logic [4:0]                    mc_rd,
  input  logic [XLEN-1:0]               mc_data,
  output logic                          mc_ready,
  output logic                          stall_wb,
  output logic                          rf_we,
  output logic [4:0]                    rf_rd,
  output logic [XLEN-1:0]               rf_wd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef WB_PEND_QUERY_EN
  ,
  input  logic [4:0]                    q_rs1,
  input  logic [4:0]                    q_rs2,
  output logic                          q_rs1_hit,
  output logic                          q_rs2_hit
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [SW-1:0]   r_starve;
  logic [4:0]      r_mem_rd   [FIFO_DEPTH];
  logic [XLEN-1:0] r_mem_data [FIFO_DEPTH];
  logic            r_rf_we;
  logic [4:0]      r_rf_rd;
  logic [XLEN-1:0] r_rf_wd;

  logic            w_pipe_req;
  logic            w_fifo_req;
  logic            w_force;
  logic            w_gnt_pipe;
  logic            w_gnt_fifo;
  logic            w_push;
  logic            w_pop;
  logic            w_we_nxt;
  logic [4:0]      w_rd_nxt;
  logic [XLEN-1:0] w_wd_nxt;
  logic [SW-1:0]   w_starve_nxt;
  logic [CW-1:0]   w_count_nxt;

  assign w_pipe_req = pipe_we && (pipe_rd != 5'd0);
  assign w_fifo_req = (r_count != '0);
  assign w_force    = w_fifo_req && (r_starve == SW'(STARVE_MAX));

  // a forced drain only matters when the pipe actually wants the port
  assign w_gnt_pipe = w_pipe_req && !w_force;
  assign w_gnt_fifo = w_fifo_req && !w_gnt_pipe;

  assign mc_ready   = (r_count < CW'(FIFO_DEPTH));
  assign w_push     = mc_valid && mc_ready;
  assign w_pop      = w_gnt_fifo;
  assign stall_wb   = w_force && w_pipe_req;

  assign rf_we      = r_rf_we;
  assign rf_rd      = r_rf_rd;
  assign rf_wd      = r_rf_wd;
  assign fifo_count = r_count;

  always_comb begin
    w_we_nxt     = 1'b0;
    w_rd_nxt     = r_rf_rd;
    w_wd_nxt     = r_rf_wd;
    w_starve_nxt = '0;
    unique case (1'b1)
      w_gnt_pipe: begin
        w_we_nxt = 1'b1;
        w_rd_nxt = pipe_rd;
        w_wd_nxt = pipe_data;
        if (w_fifo_req)
          w_starve_nxt = r_starve + SW'(1);
      end
      w_gnt_fifo: begin
        w_we_nxt = 1'b1;
        w_rd_nxt = r_mem_rd[r_head];
        w_wd_nxt = r_mem_data[r_head];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_starve <= '0;
      r_rf_we  <= 1'b0;
      r_rf_rd  <= '0;
      r_rf_wd  <= '0;
    end else begin
      r_count  <= w_count_nxt;
      r_starve <= w_starve_nxt;
      r_rf_we  <= w_we_nxt;
      r_rf_rd  <= w_rd_nxt;
      r_rf_wd  <= w_wd_nxt;
      if (w_push)
        r_tail <= r_tail + AW'(1);
      if (w_pop)
        r_head <= r_head + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_tail]   <= mc_rd;
      r_mem_data[r_tail] <= mc_data;
    end
  end

`ifdef WB_PEND_QUERY_EN
  logic [FIFO_DEPTH-1:0] w_valid;

  always_comb begin
    w_valid = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      logic [AW-1:0] v_off;
      v_off = AW'(i) - r_head;
      w_valid[i] = ({1'b0, v_off} < r_count);
    end
  end

  always_comb begin
    q_rs1_hit = 1'b0;
    q_rs2_hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (w_valid[i] && (q_rs1 != 5'd0) && (r_mem_rd[i] == q_rs1))
        q_rs1_hit = 1'b1;
      if (w_valid[i] && (q_rs2 != 5'd0) && (r_mem_rd[i] == q_rs2))
        q_rs2_hit = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_wb_port_arbiter;

  localparam int XLEN = 32;
  localparam int D    = 4;
  localparam int SM   = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            pipe_we = 1'b0;
  logic [4:0]      pipe_rd = '0;
  logic [XLEN-1:0] pipe_data = '0;
  logic            mc_valid = 1'b0;
  logic [4:0]      mc_rd = '0;
  logic [XLEN-1:0] mc_data = '0;
  logic            mc_ready;
  logic            stall_wb;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wd;
  logic [2:0]      fifo_count;

  int errors = 0;
  int checks = 0;

  wb_port_arbiter #(
    .XLEN(XLEN), .FIFO_DEPTH(D), .STARVE_MAX(SM)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data),
    .mc_ready(mc_ready), .stall_wb(stall_wb),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  int          m_starve = 0;
  logic        m_we = 1'b0;
  logic [4:0]  m_rd = '0;
  logic [31:0] m_wd = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_starve = 0;
      m_we = 1'b0;
      m_rd = '0;
      m_wd = '0;
    end else begin
      bit   preq, freq, frc, push;
      ent_t h;
      preq = pipe_we && (pipe_rd != 0);
      freq = (mq.size() != 0);
      frc  = freq && (m_starve == SM);
      push = mc_valid && (mq.size() < D);
      if (preq && !frc) begin
        m_we = 1'b1;
        m_rd = pipe_rd;
        m_wd = pipe_data;
        m_starve = freq ? m_starve + 1 : 0;
      end else if (freq) begin
        h = mq.pop_front();
        m_we = 1'b1;
        m_rd = h.rd;
        m_wd = h.d;
        m_starve = 0;
      end else begin
        m_we = 1'b0;
        m_starve = 0;
      end
      if (push) begin
        h.rd = mc_rd;
        h.d  = mc_data;
        mq.push_back(h);
      end
    end
  end

  always @(negedge clk) begin
    bit exp_stall;
    exp_stall = (mq.size() != 0) && (m_starve == SM) &&
                pipe_we && (pipe_rd != 0);
    chk("rf_we", rf_we, m_we);
    chk("rf_rd", rf_rd, m_rd);
    chk("rf_wd", rf_wd, m_wd);
    chk("stall_wb", stall_wb, exp_stall);
    chk("mc_ready", mc_ready, mq.size() < D);
    chk("fifo_count", fifo_count, mq.size());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    pipe_we  = 1'b0;
    mc_valid = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int  idx;
    bit  acc;
    #1 rst = 1'b0;
    repeat (2) tick();
    chk("rst_rf_we", rf_we, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", mc_ready, 1);
    chk("rst_stall", stall_wb, 0);
    rst = 1'b1;
    tick();

    // pipe only
    pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h1234;
    tick();
    chk("t1_we", rf_we, 1);
    chk("t1_rd", rf_rd, 5);
    chk("t1_wd", rf_wd, 32'h1234);
    pipe_we = 1'b0;
    tick();
    chk("t1_we_off", rf_we, 0);

    // multi-cycle result in idle slot
    mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'hAA;
    tick();
    chk("t2_cnt1", fifo_count, 1);
    chk("t2_we0", rf_we, 0);
    mc_valid = 1'b0;
    tick();
    chk("t2_we", rf_we, 1);
    chk("t2_rd", rf_rd, 7);
    chk("t2_wd", rf_wd, 32'hAA);
    chk("t2_cnt0", fifo_count, 0);
    idle(1);

    // starvation
    pipe_we = 1'b1; pipe_rd = 5'd20; pipe_data = 32'h20;
    mc_valid = 1'b1; mc_rd = 5'd9; mc_data = 32'h99;
    tick();
    mc_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      pipe_rd = 5'(k); pipe_data = 32'(k);
      tick();
    end
    chk("t3_rd3", rf_rd, 3);
    pipe_rd = 5'd4; pipe_data = 32'h4;
    #1 chk("t3_stall", stall_wb, 1);
    tick();
    chk("t3_rd9", rf_rd, 9);
    chk("t3_wd9", rf_wd, 32'h99);
    #1 chk("t3_nostall", stall_wb, 0);
    tick();
    chk("t3_rd4", rf_rd, 4);
    pipe_rd = 5'd5; pipe_data = 32'h5;
    tick();
    chk("t3_rd5", rf_rd, 5);
    idle(2);

    // FIFO full while pipe is busy
    idx = 0;
    pipe_we = 1'b1;
    for (int c = 0; c < 40 && idx < 5; c++) begin
      pipe_rd   = 5'(c % 5 + 1);
      pipe_data = 32'(c);
      mc_valid  = 1'b1;
      mc_rd     = 5'(11 + idx);
      mc_data   = 32'h100 + 32'(idx);
      #1 acc = mc_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx == 4) begin
          chk("t4_full_cnt", fifo_count, 4);
          chk("t4_full_ready", mc_ready, 0);
        end
      end
    end
    chk("t4_accepted", idx, 5);
    idle(1);
    chk("t4_cnt3", fifo_count, 3);
    mc_valid = 1'b1; mc_rd = 5'd16; mc_data = 32'h116;
    tick();
    chk("t4_pushpop_cnt", fifo_count, 3);
    idle(6);
    chk("t4_drained", fifo_count, 0);

    // x0 suppression
    pipe_we = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hDEAD;
    mc_valid = 1'b1; mc_rd = 5'd21; mc_data = 32'h21;
    tick();
    chk("t5_we0", rf_we, 0);
    chk("t5_cnt1", fifo_count, 1);
    mc_valid = 1'b0;
    tick();
    chk("t5_we", rf_we, 1);
    chk("t5_rd", rf_rd, 21);
    chk("t5_cnt0", fifo_count, 0);
    tick();
    chk("t5_we_x0", rf_we, 0);
    idle(1);

    // reset mid-operation
    pipe_we = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pipe_rd = 5'(k + 1); pipe_data = 32'(k + 1);
      mc_valid = 1'b1; mc_rd = 5'(25 + k); mc_data = 32'h500 + 32'(k);
      tick();
    end
    chk("t6_cnt3", fifo_count, 3);
    pipe_we = 1'b0; mc_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("t6_rst_we", rf_we, 0);
    chk("t6_rst_cnt", fifo_count, 0);
    chk("t6_rst_ready", mc_ready, 1);
    tick();
    rst = 1'b1;
    repeat (4) tick();
    chk("t6_no_stale", rf_we, 0);
    chk("t6_cnt0", fifo_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
